// File: rtl/slice_scheduler.sv
// Slice scheduler: issues one init latch after reset, then per-slice grayscale latch requests on encoder ticks/homes, and swaps the ping-pong frame buffers.
// Latency: encoder edge to SER_REQ is SYNC_STAGES+1 cycles from IDLE. Backpressure: a request holds until SER_ACK; encoder events during a transfer coalesce into one pending request, and the extra ones are counted as overruns.
module slice_scheduler #(
  parameter int NUM_SLICES  = 360,
  parameter int SLICE_W     = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic               TESTCLK,
  input  logic               nReset,
  input  logic               ENC_ABS_HOME,
  input  logic               ENC_360,
  input  logic               FRAME_DONE,
  input  logic               SER_ACK,
  input  logic               SER_DONE,
  output logic               SER_REQ,
  output logic               SER_INIT,
  output logic [SLICE_W-1:0] SER_SLICE,
  output logic               BUF_SEL,
  output logic               HOME_SEEN,
  output logic [7:0]         OVERRUN_CNT,
  output logic [3:0]         STATE_CHECK
);

  typedef enum logic [3:0] {
    INIT_REQ  = 4'd1,
    INIT_WAIT = 4'd2,
    WAIT_HOME = 4'd3,
    IDLE      = 4'd4,
    REQ       = 4'd5,
    BUSY      = 4'd6
  } state_t;

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NUM_SLICES - 1);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] home_sync_q, home_sync_d;
  logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
  logic                   home_prev_q, home_prev_d;
  logic                   tick_prev_q, tick_prev_d;
  logic [SLICE_W-1:0]     slice_q, slice_d;
  logic                   pending_q, pending_d;
  logic [7:0]             overrun_q, overrun_d;
  logic                   swap_pending_q, swap_pending_d;
  logic                   swap_armed_q, swap_armed_d;
  logic                   buf_sel_q, buf_sel_d;
  logic                   home_seen_q, home_seen_d;
  logic                   ser_req_q, ser_req_d;
  logic                   ser_init_q, ser_init_d;
  logic [SLICE_W-1:0]     ser_slice_q, ser_slice_d;

  logic home_stb, tick_stb, enc_ev;
  logic xfer_st, hold_buf, done_edge, do_swap;

  always_comb begin
    home_sync_d = {home_sync_q[SYNC_STAGES-2:0], ENC_ABS_HOME};
    tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], ENC_360};
    home_prev_d = home_sync_q[SYNC_STAGES-1];
    tick_prev_d = tick_sync_q[SYNC_STAGES-1];
    home_stb    = home_sync_q[SYNC_STAGES-1] & ~home_prev_q;
    tick_stb    = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    enc_ev      = home_stb | tick_stb;
  end

  // State register
  always_ff @(posedge TESTCLK or negedge nReset) begin
    if (!nReset) state_q <= INIT_REQ;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_REQ:  if (SER_ACK)  state_d = INIT_WAIT;
      INIT_WAIT: if (SER_DONE) state_d = WAIT_HOME;
      WAIT_HOME: if (home_stb) state_d = REQ;
      IDLE:      if (enc_ev)   state_d = REQ;
      REQ:       if (SER_ACK)  state_d = BUSY;
      BUSY:      if (SER_DONE) state_d = (pending_q || enc_ev) ? REQ : IDLE;
      default:                 state_d = INIT_REQ;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    xfer_st  = (state_q == REQ) || (state_q == BUSY);
    // The buffer may only move while no transfer (init or grayscale) is outstanding.
    hold_buf = xfer_st || (state_q == INIT_REQ) || (state_q == INIT_WAIT);
    done_edge = SER_DONE && ((state_q == BUSY) || (state_q == INIT_WAIT));

    slice_d = slice_q;
    if (home_stb && (xfer_st || state_q == IDLE || state_q == WAIT_HOME)) begin
      slice_d = '0;
    end else if (tick_stb && (xfer_st || state_q == IDLE)) begin
      slice_d = (slice_q == LAST_SLICE) ? '0 : slice_q + 1'b1;
    end

    pending_d = pending_q;
    if (state_q == BUSY && SER_DONE) pending_d = 1'b0;
    else if (xfer_st && enc_ev)      pending_d = 1'b1;

    overrun_d = overrun_q;
    if (xfer_st && enc_ev && pending_q && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;

    do_swap = swap_pending_q &&
              (hold_buf ? (done_edge && (swap_armed_q || home_stb)) : home_stb);
    buf_sel_d      = buf_sel_q ^ do_swap;
    swap_pending_d = FRAME_DONE || (swap_pending_q && !do_swap);
    swap_armed_d   = !do_swap && (swap_armed_q || (home_stb && swap_pending_q && hold_buf));

    home_seen_d = home_seen_q | home_stb;

    ser_req_d   = (state_d == INIT_REQ) || (state_d == REQ);
    ser_init_d  = (state_d == INIT_REQ) || (state_d == INIT_WAIT);
    ser_slice_d = (state_d == REQ && state_q != REQ) ? slice_d : ser_slice_q;
  end

  always_ff @(posedge TESTCLK or negedge nReset) begin
    if (!nReset) begin
      home_sync_q    <= '0;
      tick_sync_q    <= '0;
      home_prev_q    <= 1'b0;
      tick_prev_q    <= 1'b0;
      slice_q        <= '0;
      pending_q      <= 1'b0;
      overrun_q      <= 8'd0;
      swap_pending_q <= 1'b0;
      swap_armed_q   <= 1'b0;
      buf_sel_q      <= 1'b0;
      home_seen_q    <= 1'b0;
      ser_req_q      <= 1'b0;
      ser_init_q     <= 1'b1;
      ser_slice_q    <= '0;
    end else begin
      home_sync_q    <= home_sync_d;
      tick_sync_q    <= tick_sync_d;
      home_prev_q    <= home_prev_d;
      tick_prev_q    <= tick_prev_d;
      slice_q        <= slice_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      swap_pending_q <= swap_pending_d;
      swap_armed_q   <= swap_armed_d;
      buf_sel_q      <= buf_sel_d;
      home_seen_q    <= home_seen_d;
      ser_req_q      <= ser_req_d;
      ser_init_q     <= ser_init_d;
      ser_slice_q    <= ser_slice_d;
    end
  end

  assign SER_REQ     = ser_req_q;
  assign SER_INIT    = ser_init_q;
  assign SER_SLICE   = ser_slice_q;
  assign BUF_SEL     = buf_sel_q;
  assign HOME_SEEN   = home_seen_q;
  assign OVERRUN_CNT = overrun_q;
  assign STATE_CHECK = state_q;

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench for slice_scheduler: init latch, slice sequencing, overrun coalescing, wrap, buffer swaps, saturation and mid-transfer reset.
module tb_slice_scheduler;
  logic       TESTCLK = 1'b0;
  logic       nReset = 1'b0;
  logic       ENC_ABS_HOME = 1'b0;
  logic       ENC_360 = 1'b0;
  logic       FRAME_DONE = 1'b0;
  logic       SER_ACK = 1'b0;
  logic       SER_DONE = 1'b0;
  logic       SER_REQ;
  logic       SER_INIT;
  logic [8:0] SER_SLICE;
  logic       BUF_SEL;
  logic       HOME_SEEN;
  logic [7:0] OVERRUN_CNT;
  logic [3:0] STATE_CHECK;

  int n_checks = 0;
  int n_fail = 0;

  always #5 TESTCLK = ~TESTCLK;

  slice_scheduler #(.NUM_SLICES(360), .SLICE_W(9), .SYNC_STAGES(2)) dut (
    .TESTCLK(TESTCLK), .nReset(nReset), .ENC_ABS_HOME(ENC_ABS_HOME), .ENC_360(ENC_360),
    .FRAME_DONE(FRAME_DONE), .SER_ACK(SER_ACK), .SER_DONE(SER_DONE), .SER_REQ(SER_REQ),
    .SER_INIT(SER_INIT), .SER_SLICE(SER_SLICE), .BUF_SEL(BUF_SEL), .HOME_SEEN(HOME_SEEN),
    .OVERRUN_CNT(OVERRUN_CNT), .STATE_CHECK(STATE_CHECK)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge TESTCLK);
    #1;
  endtask

  task automatic pulse_enc(input logic h, input logic t);
    ENC_ABS_HOME = h;
    ENC_360 = t;
    step(3);
    ENC_ABS_HOME = 1'b0;
    ENC_360 = 1'b0;
    step(3);
  endtask

  task automatic pulse_frame_done();
    FRAME_DONE = 1'b1;
    step(1);
    FRAME_DONE = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (SER_REQ) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic ack_req();
    SER_ACK = 1'b1;
    step(1);
    SER_ACK = 1'b0;
  endtask

  task automatic serve(input string tag, input int exp_slice, input int exp_init, input int dly);
    bit ok;
    wait_req(ok);
    check_eq({tag, "_req"}, 32'(ok), 1);
    if (ok) begin
      check_eq({tag, "_slice"}, 32'(SER_SLICE), exp_slice);
      check_eq({tag, "_init"}, 32'(SER_INIT), exp_init);
      ack_req();
      check_eq({tag, "_reqfall"}, 32'(SER_REQ), 0);
      check_eq({tag, "_busy"}, 32'(STATE_CHECK), (exp_init != 0) ? 2 : 6);
      step(dly);
      SER_DONE = 1'b1;
      step(1);
      SER_DONE = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, 32'(SER_REQ), 0);
    check_eq({tag, "_init"}, 32'(SER_INIT), 1);
    check_eq({tag, "_slice"}, 32'(SER_SLICE), 0);
    check_eq({tag, "_buf"}, 32'(BUF_SEL), 0);
    check_eq({tag, "_home"}, 32'(HOME_SEEN), 0);
    check_eq({tag, "_ovr"}, 32'(OVERRUN_CNT), 0);
    check_eq({tag, "_state"}, 32'(STATE_CHECK), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected finish");
    $fatal(1);
  end

  initial begin
    step(3);
    check_reset_vals("rst");
    nReset = 1'b1;
    step(1);
    check_eq("rel_req", 32'(SER_REQ), 1);
    check_eq("rel_init", 32'(SER_INIT), 1);
    serve("init", 0, 1, 4);
    check_eq("wait_home_state", 32'(STATE_CHECK), 3);
    for (int i = 0; i < 5; i++) begin
      pulse_enc(1'b0, 1'b1);
      check_eq("wait_home_noreq", 32'(SER_REQ), 0);
    end
    check_eq("wait_home_hold", 32'(STATE_CHECK), 3);

    // Home, then three slow ticks with long transfers.
    pulse_enc(1'b1, 1'b0);
    check_eq("home_seen", 32'(HOME_SEEN), 1);
    serve("seq0", 0, 0, 1600);
    check_eq("seq_idle", 32'(STATE_CHECK), 4);
    for (int i = 1; i <= 3; i++) begin
      step(390);
      pulse_enc(1'b0, 1'b1);
      serve("seq", i, 0, 1600);
    end
    check_eq("seq_ovr", 32'(OVERRUN_CNT), 0);

    // Encoder edge to request latency from IDLE.
    step(5);
    ENC_360 = 1'b1;
    step(2);
    check_eq("lat_early", 32'(SER_REQ), 0);
    step(1);
    check_eq("lat_req", 32'(SER_REQ), 1);
    ENC_360 = 1'b0;
    step(3);
    serve("lat", 4, 0, 5);

    // Three ticks inside one transfer coalesce into one follow-up.
    begin
      bit ok;
      pulse_enc(1'b0, 1'b1);
      wait_req(ok);
      check_eq("ovr_req", 32'(ok), 1);
      check_eq("ovr_slice", 32'(SER_SLICE), 5);
      ack_req();
      repeat (3) pulse_enc(1'b0, 1'b1);
      check_eq("ovr_busy", 32'(STATE_CHECK), 6);
      check_eq("ovr_noreq", 32'(SER_REQ), 0);
      SER_DONE = 1'b1;
      step(1);
      SER_DONE = 1'b0;
      check_eq("ovr_rereq", 32'(SER_REQ), 1);
      serve("ovr_follow", 8, 0, 5);
      check_eq("ovr_cnt", 32'(OVERRUN_CNT), 2);
    end

    // Full revolution without home wraps 359 -> 0.
    pulse_enc(1'b1, 1'b0);
    serve("wrap_home", 0, 0, 2);
    for (int i = 1; i <= 360; i++) begin
      pulse_enc(1'b0, 1'b1);
      serve("wrap", i % 360, 0, 1);
    end
    pulse_enc(1'b0, 1'b1);
    serve("pre_both", 1, 0, 1);
    pulse_enc(1'b1, 1'b1);
    serve("home_tick", 0, 0, 1);

    // Swap deferred to SER_DONE when home lands during a transfer.
    begin
      bit ok;
      pulse_frame_done();
      pulse_enc(1'b0, 1'b1);
      wait_req(ok);
      check_eq("bufb_req", 32'(ok), 1);
      ack_req();
      pulse_enc(1'b1, 1'b0);
      check_eq("bufb_hold", 32'(BUF_SEL), 0);
      SER_DONE = 1'b1;
      #2;
      check_eq("bufb_predone", 32'(BUF_SEL), 0);
      step(1);
      SER_DONE = 1'b0;
      check_eq("bufb_swap", 32'(BUF_SEL), 1);
      serve("bufb_follow", 0, 0, 3);
      check_eq("bufb_keep", 32'(BUF_SEL), 1);
    end

    // Swap on the home strobe when idle.
    pulse_frame_done();
    step(2);
    ENC_ABS_HOME = 1'b1;
    step(2);
    check_eq("bufi_pre", 32'(BUF_SEL), 1);
    step(1);
    check_eq("bufi_swap", 32'(BUF_SEL), 0);
    ENC_ABS_HOME = 1'b0;
    step(3);
    serve("bufi", 0, 0, 3);
    pulse_enc(1'b1, 1'b0);
    serve("bufn", 0, 0, 3);
    check_eq("buf_noframe", 32'(BUF_SEL), 0);

    // Overrun saturation, then reset in the middle of the transfer.
    begin
      bit ok;
      pulse_enc(1'b0, 1'b1);
      wait_req(ok);
      check_eq("sat_req", 32'(ok), 1);
      ack_req();
      repeat (100) pulse_enc(1'b0, 1'b1);
      check_eq("sat_mid", 32'(OVERRUN_CNT), 101);
      repeat (200) pulse_enc(1'b0, 1'b1);
      check_eq("sat_cnt", 32'(OVERRUN_CNT), 255);
      check_eq("sat_busy", 32'(STATE_CHECK), 6);
    end
    nReset = 1'b0;
    #1;
    check_reset_vals("midrst");
    step(2);
    nReset = 1'b1;
    step(1);
    check_eq("rerel_req", 32'(SER_REQ), 1);
    serve("reinit", 0, 1, 4);
    check_eq("rewait_state", 32'(STATE_CHECK), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/slice_scheduler.md
# slice_scheduler

Sequences the TLC-style LED driver shift/latch datapath against the rotating display. Performs the one-time control-data latch after reset. Turns encoder home/slice pulses into per-slice grayscale latch requests. Arbitrates the ping-pong LED frame buffers between the HDMI frame writer and the serializer. Sits between the encoder inputs, the frame writer and the serializer FSM, all in the TESTCLK domain.

## Interface
Parameters:
- NUM_SLICES, 360, slices per revolution; slice index wraps at NUM_SLICES-1.
- SLICE_W, 9, width of slice index (must satisfy 2**SLICE_W >= NUM_SLICES).
- SYNC_STAGES, 2, synchronizer flops on each encoder input (>=2).

Ports:
- TESTCLK  in  1  serializer clock; all logic on its rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- ENC_ABS_HOME  in  1  async encoder home pulse, once per revolution.
- ENC_360  in  1  async encoder slice tick.
- FRAME_DONE  in  1  one-cycle pulse: writer finished filling the back buffer.
- SER_ACK  in  1  serializer accepted the current request.
- SER_DONE  in  1  one-cycle pulse: serializer asserted LAT for the request.
- SER_REQ  out  1  request to shift and latch one 769-bit word per chained driver.
- SER_INIT  out  1  1 = control-data latch, 0 = grayscale latch; valid with SER_REQ.
- SER_SLICE  out  SLICE_W  slice to serialize; valid with SER_REQ.
- BUF_SEL  out  1  buffer the serializer reads (0 = LED_data_1, 1 = LED_data_2); the writer owns the other.
- HOME_SEEN  out  1  at least one home edge since reset.
- OVERRUN_CNT  out  8  dropped-slice count, saturates at 255.
- STATE_CHECK  out  4  current FSM state code.

## Operation
- Encoder inputs pass through SYNC_STAGES flops, then a rising-edge detector; tick/home are one-cycle internal strobes.
- States, with STATE_CHECK codes:
  - INIT_REQ=1: SER_REQ=1, SER_INIT=1; on SER_ACK go to INIT_WAIT.
  - INIT_WAIT=2: wait for SER_DONE, then go to WAIT_HOME.
  - WAIT_HOME=3: ignore ticks; on home go to REQ with slice=0.
  - IDLE=4: on tick or home go to REQ.
  - REQ=5: SER_REQ=1, SER_INIT=0, SER_SLICE=slice; on SER_ACK go to BUSY.
  - BUSY=6: on SER_DONE go to REQ if pending, else IDLE.
- Reset enters INIT_REQ. The init sequence is issued once per reset only.
- Slice counter:
  - home sets slice to 0 and HOME_SEEN to 1.
  - tick increments slice; NUM_SLICES-1 wraps to 0.
  - home and tick in the same cycle: home wins, slice=0.
  - Counter updates in every state after WAIT_HOME, including REQ and BUSY.
- Overrun:
  - A tick or home in REQ or BUSY sets pending.
  - A tick or home while pending is already set increments OVERRUN_CNT (saturating at 255).
  - The pending request always uses the latest slice index.
- SER_SLICE is captured on entry to REQ and held stable until SER_ACK. Slice changes during REQ do not alter it; they set pending.
- Buffer arbitration:
  - FRAME_DONE sets swap_pending.
  - On a home strobe with swap_pending, BUF_SEL toggles, provided the state is not REQ or BUSY.
  - Otherwise the toggle is deferred to the SER_DONE cycle.
  - Swap clears swap_pending. FRAME_DONE in the same cycle as a swap re-sets it (set wins).
  - BUF_SEL never changes while SER_REQ=1 or in BUSY, except on the SER_DONE edge.
- SER_DONE outside INIT_WAIT/BUSY and SER_ACK outside INIT_REQ/REQ are ignored.

## Timing
- Reset values: SER_REQ=0 (rises the first cycle after release), SER_INIT=1, SER_SLICE=0, BUF_SEL=0, HOME_SEEN=0, OVERRUN_CNT=0, STATE_CHECK=1.
- All outputs are registered.
- Encoder rising edge to SER_REQ: SYNC_STAGES+1 cycles from the IDLE state.
- SER_REQ falls the cycle after SER_ACK is sampled high; the state is BUSY that cycle.
- SER_DONE with pending: SER_REQ reasserts the next cycle.
- nReset low mid-transfer: immediate return to reset values. The serializer is reset by the same nReset.

## Test plan
- Reset release: SER_REQ=1/SER_INIT=1 within 1 cycle; ACK, then DONE → WAIT_HOME (STATE_CHECK=3); 5 ticks produce no requests.
- Home then 3 ticks spaced 2000 cycles, each ACK+DONE after 1600 cycles → requests SER_SLICE=0,1,2,3 with SER_INIT=0; OVERRUN_CNT=0.
- 3 ticks during one BUSY window → one follow-up request with the latest slice; OVERRUN_CNT=2.
- 360 ticks with no home → slice wraps 359→0; home and tick in the same cycle → slice 0, not 1.
- FRAME_DONE then home while BUSY → BUF_SEL toggles exactly on the SER_DONE cycle. FRAME_DONE then home in IDLE → toggles on the home-strobe cycle.
- 300 forced overruns → OVERRUN_CNT saturates at 255. nReset pulse mid-BUSY → all outputs return to reset values and the init latch is reissued.
